// File: rtl/data_mem_responder_if.sv
// Load/store bus between the cpu (master) and the data-memory responder (slave).
// One word request at a time; ready/rvalid/err report progress back to the cpu.
interface data_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              rvalid;
  logic              err;

  modport master (
    output write, read, address, wdata,
    input  rdata, ready, rvalid, err
  );

  modport slave (
    input  write, read, address, wdata,
    output rdata, ready, rvalid, err
  );

endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: slave end of the cpu load/store bus in front of an
// on-chip word RAM. Accepts one request, waits LATENCY cycles, then commits
// the write or returns the read word with a one-cycle rvalid pulse.
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject addresses >= DEPTH
// (write dropped, read returns 32'hDEAD_BEEF, err pulses). Without it the
// address wraps modulo DEPTH and err stays 0.
module data_mem_responder #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic              op_write;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              done;
  logic              in_range;
  logic              ram_we;

  assign idx  = address_q[IDX_W-1:0];
  assign done = (state == BUSY) && (cnt == 4'd0);

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;

  assign in_range = (64'(address_q) < 64'(DEPTH));
  assign bus.err  = err_q;
`else
  // Upper address bits are ignored: the RAM index wraps modulo DEPTH.
  logic unused_addr_bits;

  assign unused_addr_bits = ^address_q[ADDR_W-1:IDX_W];
  assign in_range         = 1'b1;
  assign bus.err          = 1'b0;
`endif

  assign ram_we     = done && op_write && in_range;
  assign bus.ready  = (state == IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

  // Request FSM: latch in IDLE, count wait states in BUSY, complete when cnt hits 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples the pre-edge values; blocking would make ordering matter.
      rvalid_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.write || bus.read) begin
            address_q <= bus.address;
            wdata_q   <= bus.wdata;
            op_write  <= bus.write;   // write wins when both are high
            cnt       <= LAT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (!op_write) begin
              rvalid_q <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
              rdata_q  <= in_range ? mem[idx] : DATA_W'(32'hDEAD_BEEF);
`else
              rdata_q  <= mem[idx];
`endif
            end
`ifdef MEM_BOUNDS_CHECK_EN
            err_q <= !in_range;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port: commits the latched write on the completion edge.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately outside the reset domain; an aborted
    // access never reaches ram_we because rst forces the FSM back to IDLE.
    if (ram_we && !rst) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
